// File: rtl/u_mem_pkg.sv
// Shared constants and types for the local-memory arbiter.
// Two masters share one single-beat memory port.
package u_mem_pkg;
  localparam int U_MEM_ADDR_WIDTH      = 32;
  localparam int U_MEM_DATA_WIDTH      = 512;
  localparam int U_MEM_MAX_OUTSTANDING = 64;
  localparam int U_MEM_BURST_WIDTH     = 7;

  typedef logic master_id_t;

  localparam master_id_t MID_M0 = 1'b0;
  localparam master_id_t MID_M1 = 1'b1;
endpackage

// File: rtl/u_mem_tag_fifo.sv
// Read-tag FIFO: remembers which master issued each outstanding read.
// Push is ignored when full, pop is ignored when empty.
module u_mem_tag_fifo
  import u_mem_pkg::*;
#(
  parameter int DEPTH = U_MEM_MAX_OUTSTANDING
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  master_id_t             push_id,
  input  logic                   pop,
  output master_id_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  master_id_t        mem_q [DEPTH];
  master_id_t        mem_d [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign count   = cnt_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = push_id;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: MID_M0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/u_mem_arbiter.sv
// Round-robin arbiter of two single-beat masters onto one memory port,
// routing read responses back through a tag FIFO.
module u_mem_arbiter
  import u_mem_pkg::*;
#(
  parameter int ADDR_WIDTH      = U_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH      = U_MEM_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = U_MEM_MAX_OUTSTANDING
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [ADDR_WIDTH-1:0]            m0_address,
  input  logic                             m0_read,
  input  logic                             m0_write,
  input  logic [DATA_WIDTH-1:0]            m0_writedata,
  input  logic [DATA_WIDTH/8-1:0]          m0_byteenable,
  output logic                             m0_waitrequest,
  output logic [DATA_WIDTH-1:0]            m0_readdata,
  output logic                             m0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]            m1_address,
  input  logic                             m1_read,
  input  logic                             m1_write,
  input  logic [DATA_WIDTH-1:0]            m1_writedata,
  input  logic [DATA_WIDTH/8-1:0]          m1_byteenable,
  output logic                             m1_waitrequest,
  output logic [DATA_WIDTH-1:0]            m1_readdata,
  output logic                             m1_readdatavalid,
  output logic [ADDR_WIDTH-1:0]            s_address,
  output logic                             s_read,
  output logic                             s_write,
  output logic [DATA_WIDTH-1:0]            s_writedata,
  output logic [DATA_WIDTH/8-1:0]          s_byteenable,
  output logic [U_MEM_BURST_WIDTH-1:0]     s_burstcount,
  input  logic                             s_waitrequest,
  input  logic [DATA_WIDTH-1:0]            s_readdata,
  input  logic                             s_readdatavalid,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             err_orphan
);
  logic       rst_meta_q, rst_sync_q, rst_n;
  master_id_t ptr_q, ptr_d;
  logic       err_orphan_q, err_orphan_d;
  master_id_t gnt, head;
  logic       req0, req1, any_req;
  logic       gnt_read, gnt_write, accept;
  logic       push, pop;
  logic       fifo_full, fifo_empty;

  // Async assert, sync release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_n = rst_sync_q;

  always_comb begin
    req0    = m0_write | (m0_read & ~fifo_full);
    req1    = m1_write | (m1_read & ~fifo_full);
    any_req = rst_n & (req0 | req1);
    if (req0 && req1) begin
      gnt = ptr_q;
    end else if (req1) begin
      gnt = MID_M1;
    end else begin
      gnt = MID_M0;
    end
  end

  always_comb begin
    s_address    = m0_address;
    s_writedata  = m0_writedata;
    s_byteenable = m0_byteenable;
    gnt_read     = m0_read;
    gnt_write    = m0_write;
    if (gnt == MID_M1) begin
      s_address    = m1_address;
      s_writedata  = m1_writedata;
      s_byteenable = m1_byteenable;
      gnt_read     = m1_read;
      gnt_write    = m1_write;
    end
  end

  // Read+write together is treated as a write.
  assign s_write      = any_req & gnt_write;
  assign s_read       = any_req & gnt_read & ~gnt_write;
  assign s_burstcount = U_MEM_BURST_WIDTH'(1);
  assign accept       = (s_read | s_write) & ~s_waitrequest;

  assign m0_waitrequest = ~(accept & (gnt == MID_M0));
  assign m1_waitrequest = ~(accept & (gnt == MID_M1));

  assign push = accept & s_read;
  assign pop  = rst_n & s_readdatavalid & ~fifo_empty;

  assign m0_readdatavalid = pop & (head == MID_M0);
  assign m1_readdatavalid = pop & (head == MID_M1);
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;

  always_comb begin
    ptr_d        = accept ? ~gnt : ptr_q;
    err_orphan_d = err_orphan_q | (rst_n & s_readdatavalid & fifo_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= MID_M0;
      err_orphan_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign err_orphan = err_orphan_q;

  u_mem_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .push_id(gnt),
    .pop    (pop),
    .head   (head),
    .count  (outstanding),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );
endmodule

// File: doc/u_mem_arbiter.md
U_MEM_ARBITER -- requirements
Module: u_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, local-memory line address width (matches U_MEM_ADDR_WIDTH).
REQ-002 Parameter DATA_WIDTH, default 512, data beat width; byteenable width is DATA_WIDTH/8.
REQ-003 Parameter MAX_OUTSTANDING, default 64, read-tag FIFO depth (power of two).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 m0_address/m0_read/m0_write/m0_writedata/m0_byteenable  input  ADDR_WIDTH/1/1/DATA_WIDTH/DATA_WIDTH/8  master 0 (DMA engine) request.
REQ-007 m0_waitrequest/m0_readdata/m0_readdatavalid  output  1/DATA_WIDTH/1  master 0 response.
REQ-008 m1_*  same set and widths as m0_*  master 1 (kernel datapath).
REQ-009 s_address/s_read/s_write/s_writedata/s_byteenable/s_burstcount  output  ADDR_WIDTH/1/1/DATA_WIDTH/DATA_WIDTH/8/7  to local-memory controller.
REQ-010 s_waitrequest/s_readdata/s_readdatavalid  input  1/DATA_WIDTH/1  from local-memory controller.
REQ-011 outstanding  output  $clog2(MAX_OUTSTANDING)+1  reads accepted by the memory but not yet returned.
REQ-012 err_orphan  output  1  sticky: readdatavalid arrived with no outstanding tag.

Function
REQ-013 Single-beat only: s_burstcount SHALL be constant 1; a master asserting read and write together is illegal and SHALL be treated as write.
REQ-014 Request of master i = mi_read | mi_write; read requests SHALL count as requesting only when the tag FIFO is not full (count < MAX_OUTSTANDING, regardless of a same-cycle pop).
REQ-015 Grant SHALL be combinational round-robin: with one requester it wins; with two, the master indicated by the priority pointer wins.
REQ-016 s_* request signals SHALL mux the granted master's signals; s_read/s_write SHALL be 0 when no master requests.
REQ-017 mi_waitrequest SHALL be 0 only when master i is granted and s_waitrequest is 0; otherwise 1 (including read blocked on full FIFO).
REQ-018 A transfer is accepted when (s_read|s_write) & ~s_waitrequest; on acceptance the priority pointer SHALL move to the non-granted master on the next edge.
REQ-019 On accepted read, the granted master ID SHALL be pushed into the tag FIFO the same edge.
REQ-020 On s_readdatavalid with FIFO non-empty, the head ID SHALL be popped and mi_readdatavalid asserted combinationally, same cycle, for that master only; both mi_readdata SHALL equal s_readdata.
REQ-021 Simultaneous push and pop SHALL leave outstanding unchanged; outstanding = pushes − pops, never wrapping.
REQ-022 s_readdatavalid with FIFO empty SHALL be dropped (no mi_readdatavalid) and set err_orphan until reset.
REQ-023 Writes SHALL not touch the tag FIFO; a write accepted while reads are outstanding is permitted (memory ordering is the controller's responsibility).
REQ-024 Returned data order per master SHALL equal its issue order.

Reset
REQ-025 While reset_n=0: priority pointer = master 0, tag FIFO empty, outstanding = 0, err_orphan = 0, s_read = s_write = 0, mi_readdatavalid = 0, mi_waitrequest = 1.
REQ-026 Reset mid-operation SHALL discard all outstanding tags; responses arriving after reset follow REQ-022.
REQ-027 Release of reset_n SHALL be synchronised (async assert, sync deassert) inside the block.

Structure
REQ-028 ADDR/DATA width constants, MAX_OUTSTANDING default and a 1-bit master-ID typedef SHALL live in shared package u_mem_pkg.
REQ-029 The tag FIFO SHALL be a separate sub-module u_mem_tag_fifo (push, pop, head, count, full, empty).

Verification
REQ-030 Both masters write continuously, s_waitrequest=0 -> grants alternate m0,m1,m0,...; 8 writes each land at correct addresses.
REQ-031 m0 reads A0..A3, m1 reads B0..B3 interleaved, memory returns after 10-cycle latency -> each master receives its own 4 beats in issue order; outstanding peaks at 8, returns to 0.
REQ-032 m1 issues 64 reads with no returns -> 65th read held with m1_waitrequest=1, outstanding=64; one return releases it next cycle.
REQ-033 s_readdatavalid pulse with outstanding=0 -> no mi_readdatavalid, err_orphan=1 and stays 1.
REQ-034 Assert reset_n=0 with 5 reads outstanding -> outstanding=0, err_orphan=0, pointer=m0; next arbitration with both requesting grants m0.
REQ-035 s_waitrequest=1 for 20 cycles with both requesting -> no acceptance, pointer unchanged, granted master held until accepted.
